fir_xifu_simd_mac: RTL and testbench
====================================

// Module: fir_xifu_simd_mac
// PURPOSE
//  Parametrised SIMD multiply-accumulate engine for the FIR XIF coprocessor: LANES signed DW-bit
//  sample x coefficient products per instruction into NB_REGS vector accumulators.
//  Sits between XIF issue/decode and writeback. Holds each op until its XIF commit/kill arrives.
//  Returns one result per committed op; RDSAT also returns a shifted, saturated lane-sum for rd.
// PARAMETERS
//  LANES   2   SIMD lanes per operand
//  DW      16  signed sample/coefficient width per lane
//  AW      40  accumulator width per lane (AW >= 2*DW)
//  NB_REGS 4   number of vector accumulators
//  XLEN    32  result width
//  ID_W    4   XIF instruction-id width
// PORTS
//  clk_i          in   1              clock
//  rst_i          in   1              asynchronous active-high reset
//  clear_i        in   1              sync flush of in-flight ops (kill from WB)
//  req_valid_i    in   1              request valid
//  req_ready_o    out  1              request ready
//  req_op_i       in   2              fir_xifu_mac_op_e: MAC=0, CLR=1, RDSAT=2, NOP=3
//  req_acc_i      in   clog2(NB_REGS) accumulator index
//  req_id_i       in   ID_W           XIF instruction id
//  req_a_i        in   LANES*DW       packed samples, lane 0 in LSBs
//  req_b_i        in   LANES*DW       packed coefficients
//  req_shift_i    in   6              RDSAT arithmetic right shift, 0..63
//  commit_valid_i in   1              XIF commit strobe
//  commit_id_i    in   ID_W           committed id
//  commit_kill_i  in   1              1 = discard the op with commit_id_i
//  res_valid_o    out  1              result valid
//  res_ready_i    in   1              result ready
//  res_id_o       out  ID_W           id of retired op
//  res_we_o       out  1              1 only for RDSAT
//  res_data_o     out  XLEN           RDSAT value, else 0
// BEHAVIOUR
//  - Reset: req_ready_o=0 while rst_i, 1 afterwards; res_valid_o/res_we_o=0; res_id_o, res_data_o=0;
//    accumulators, stage valids and commit table all 0. Reset mid-op drops every op, no result.
//  - Handshakes valid/ready; transfer on valid&&ready; res_* stable while res_valid_o&&!res_ready_i.
//  - Pipeline: S1 operand reg -> S2 product reg -> retire -> result reg. Op accepted at cycle t gives
//    res_valid_o at t+3 if commit seen by t+2 and no backpressure. Throughput 1 op/cycle.
//  - Retire in S2 only when its id is committed (same-cycle commit counts). Else S2 stalls,
//    back-pressure to S1 and req_ready_o. Also stall if result reg full and !res_ready_i.
//  - Killed op: leaves S2 with no accumulator update and no result.
//  - MAC: acc[r][l] += sext(a[l]*b[l]) mod 2^AW. CLR: acc[r][*]=0. NOP: no acc change.
//  - RDSAT: s = sum of lanes at AW+clog2(LANES) bits; s >>>= shift; saturate to signed XLEN.
//  - Ops retire in order. RDSAT sees all older MAC/CLR retired to the same acc, even back-to-back.
//  - Commit table has 2^ID_W entries of {seen, kill}. Set on commit_valid_i; cleared when the op
//    retires. Commit in the cycle the op is accepted is recorded.
//  - clear_i: S1/S2 valids and commit table cleared next edge. Result reg and accumulators kept.
//    req_ready_o=0 in that cycle; clear wins over a simultaneous request or commit.
// CONFIGURATION
//  FIR_XIFU_ROUND_EN defined: RDSAT adds 1<<(shift-1) before shift when shift>0 (round-half-up).
//  Undefined: plain truncating arithmetic shift. NOP/MAC/CLR unaffected either way.
// STRUCTURE
//  fir_xifu_pkg: fir_xifu_mac_op_e, fir_xifu_mac_req_t, fir_xifu_mac_res_t, lane/acc width
//  localparams. Sub-module fir_xifu_commit_tbl: id-indexed seen/kill table with set and
//  clear-on-retire ports plus a same-cycle commit bypass.
// TESTING
//  - MAC acc0 a={3,-2} b={4,5}, commit next cycle, then RDSAT acc0 shift0 -> res_data_o=2,
//    we=1; MAC result at t+3 with we=0.
//  - Commit withheld 5 cycles on a MAC -> S2 stalls, req_ready_o=0 after the pipeline fills;
//    retires the cycle after commit.
//  - MAC id=7 killed, then RDSAT -> no result for id 7; accumulator unchanged.
//  - acc0 lanes each 0x7F_FFFF_FFFF, RDSAT shift0 -> 0x7FFF_FFFF; lanes -2^39 each -> 0x8000_0000.
//  - RDSAT sum=3 shift=1 -> 1 without FIR_XIFU_ROUND_EN, 2 with it.
//  - clear_i with ops in S1/S2 -> both dropped, no results; accumulators keep their values.

Source files
------------

// File: rtl/fir_xifu_pkg.sv
// Shared types and widths for the FIR XIF SIMD MAC engine.
// The struct widths follow the default engine configuration below.
package fir_xifu_pkg;

  localparam int FIR_LANES     = 2;
  localparam int FIR_DW        = 16;
  localparam int FIR_AW        = 40;
  localparam int FIR_NB_REGS   = 4;
  localparam int FIR_XLEN      = 32;
  localparam int FIR_ID_W      = 4;
  localparam int FIR_ACC_IDX_W = (FIR_NB_REGS > 1) ? $clog2(FIR_NB_REGS) : 1;
  localparam int FIR_SUM_W     = FIR_AW + $clog2(FIR_LANES);

  typedef enum logic [1:0] {
    FIR_MAC   = 2'd0,
    FIR_CLR   = 2'd1,
    FIR_RDSAT = 2'd2,
    FIR_NOP   = 2'd3
  } fir_xifu_mac_op_e;

  typedef struct packed {
    fir_xifu_mac_op_e               op;
    logic [FIR_ACC_IDX_W-1:0]       acc;
    logic [FIR_ID_W-1:0]            id;
    logic [FIR_LANES*FIR_DW-1:0]    a;
    logic [FIR_LANES*FIR_DW-1:0]    b;
    logic [5:0]                     shift;
  } fir_xifu_mac_req_t;

  typedef struct packed {
    logic [FIR_ID_W-1:0] id;
    logic                we;
    logic [FIR_XLEN-1:0] data;
  } fir_xifu_mac_res_t;

  // Index width that stays legal for a single-entry range.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_xifu_commit_tbl.sv
// Id-indexed {seen, kill} table for XIF commit tracking. A commit
// arriving in the same cycle as the lookup is forwarded to the query port.
module fir_xifu_commit_tbl #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            set_valid,
  input  logic [ID_W-1:0] set_id,
  input  logic            set_kill,
  input  logic            ret_valid,
  input  logic [ID_W-1:0] ret_id,
  input  logic [ID_W-1:0] query_id,
  output logic            query_seen,
  output logic            query_kill
);

  localparam int N = 1 << ID_W;

  logic [N-1:0] seen;
  logic [N-1:0] kill;
  logic         hit;

  // Same-cycle commit bypass for the op currently waiting to retire.
  always_comb begin
    hit        = set_valid && (set_id == query_id);
    query_seen = seen[query_id] | hit;
    query_kill = hit ? set_kill : kill[query_id];
  end

  // Record commits; retirement releases the entry (and wins over a bypassed commit).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen <= '0;
      kill <= '0;
    end else if (clear) begin
      seen <= '0;
      kill <= '0;
    end else begin
      if (set_valid) begin
        seen[set_id] <= 1'b1;
        kill[set_id] <= set_kill;
      end
      if (ret_valid) begin
        seen[ret_id] <= 1'b0;
        kill[ret_id] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fir_xifu_simd_mac.sv
// SIMD multiply-accumulate engine for the FIR XIF coprocessor.
// Pipeline: operand reg (_p1) -> product reg (_p2) -> commit-gated retire -> result reg.
// Build option: define FIR_XIFU_ROUND_EN for round-half-up on RDSAT; otherwise RDSAT truncates.
module fir_xifu_simd_mac
  import fir_xifu_pkg::*;
#(
  parameter int LANES   = FIR_LANES,
  parameter int DW      = FIR_DW,
  parameter int AW      = FIR_AW,
  parameter int NB_REGS = FIR_NB_REGS,
  parameter int XLEN    = FIR_XLEN,
  parameter int ID_W    = FIR_ID_W
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [1:0]                       req_op_i,
  input  logic [clog2_min1(NB_REGS)-1:0]   req_acc_i,
  input  logic [ID_W-1:0]                  req_id_i,
  input  logic [LANES*DW-1:0]              req_a_i,
  input  logic [LANES*DW-1:0]              req_b_i,
  input  logic [5:0]                       req_shift_i,
  input  logic                             commit_valid_i,
  input  logic [ID_W-1:0]                  commit_id_i,
  input  logic                             commit_kill_i,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [ID_W-1:0]                  res_id_o,
  output logic                             res_we_o,
  output logic [XLEN-1:0]                  res_data_o
);

  localparam int ACC_IDX_W = clog2_min1(NB_REGS);
  localparam int PROD_W    = 2 * DW;
  localparam int SUM_W     = AW + $clog2(LANES);
  // Working width for shift/round: wide enough that a 63-bit rounding
  // constant and the saturation bounds are both representable.
  localparam int WW_A      = (SUM_W + 2 > 65) ? SUM_W + 2 : 65;
  localparam int WW        = (WW_A > XLEN + 1) ? WW_A : XLEN + 1;

  function automatic logic signed [WW-1:0] shift_round(input logic signed [SUM_W-1:0] s,
                                                        input logic [5:0] sh);
    logic signed [WW-1:0] w;
    w = WW'(s);
`ifdef FIR_XIFU_ROUND_EN
    if (sh != 6'd0) w = w + (WW'(1) << (sh - 6'd1));
`endif
    return w >>> sh;
  endfunction

  function automatic logic [XLEN-1:0] sat_xlen(input logic signed [WW-1:0] v);
    logic signed [WW-1:0] mx;
    logic signed [WW-1:0] mn;
    mx = WW'({1'b0, {(XLEN-1){1'b1}}});
    mn = ~mx;
    if (v > mx)      return mx[XLEN-1:0];
    else if (v < mn) return mn[XLEN-1:0];
    else             return v[XLEN-1:0];
  endfunction

  logic                    ready_en;
  logic                    vld_p1;
  fir_xifu_mac_op_e        op_p1;
  logic [ACC_IDX_W-1:0]    acc_p1;
  logic [ID_W-1:0]         id_p1;
  logic [LANES*DW-1:0]     a_p1;
  logic [LANES*DW-1:0]     b_p1;
  logic [5:0]              shift_p1;

  logic                    vld_p2;
  fir_xifu_mac_op_e        op_p2;
  logic [ACC_IDX_W-1:0]    acc_p2;
  logic [ID_W-1:0]         id_p2;
  logic signed [PROD_W-1:0] prod_p2 [LANES];
  logic [5:0]              shift_p2;

  logic signed [PROD_W-1:0] prod_c [LANES];
  logic signed [AW-1:0]    acc_q [NB_REGS][LANES];
  logic signed [SUM_W-1:0] lane_sum;
  logic [XLEN-1:0]         rdsat_val;

  logic seen_p2, kill_p2;
  logic res_free, retire_p2, update_p2, free_p2, free_p1, move_p1, accept;

  // Handshake and stall network: S2 retires only once committed and, unless
  // killed, only when the result register can take it.
  always_comb begin
    res_free    = !res_valid_o || res_ready_i;
    retire_p2   = vld_p2 && seen_p2 && !clear_i && (kill_p2 || res_free);
    update_p2   = retire_p2 && !kill_p2;
    free_p2     = !vld_p2 || retire_p2;
    free_p1     = !vld_p1 || free_p2;
    move_p1     = vld_p1 && free_p2;
    req_ready_o = ready_en && !clear_i && free_p1;
    accept      = req_valid_i && req_ready_o;
  end

  fir_xifu_commit_tbl #(.ID_W(ID_W)) u_commit_tbl (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (clear_i),
    .set_valid  (commit_valid_i),
    .set_id     (commit_id_i),
    .set_kill   (commit_kill_i),
    .ret_valid  (retire_p2),
    .ret_id     (id_p2),
    .query_id   (id_p2),
    .query_seen (seen_p2),
    .query_kill (kill_p2)
  );

  // Stage valids and the post-reset ready enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_en <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (clear_i) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        vld_p1 <= accept || (vld_p1 && !free_p2);
        vld_p2 <= move_p1 || (vld_p2 && !retire_p2);
      end
    end
  end

  // ---- Stage 1: operand register ----
  // Capture the accepted request operands.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_p1    <= fir_xifu_mac_op_e'(req_op_i);
      acc_p1   <= req_acc_i;
      id_p1    <= req_id_i;
      a_p1     <= req_a_i;
      b_p1     <= req_b_i;
      shift_p1 <= req_shift_i;
    end
  end

  // Per-lane signed products; 2*DW bits hold any product exactly.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_c[l] = PROD_W'($signed(a_p1[l*DW +: DW])) * PROD_W'($signed(b_p1[l*DW +: DW]));
    end
  end

  // ---- Stage 2: product register ----
  // Move the op and its products forward when S2 has room.
  always_ff @(posedge clk_i) begin
    if (move_p1) begin
      op_p2    <= op_p1;
      acc_p2   <= acc_p1;
      id_p2    <= id_p1;
      shift_p2 <= shift_p1;
      for (int l = 0; l < LANES; l++) prod_p2[l] <= prod_c[l];
    end
  end

  // RDSAT value from the selected accumulator, which already holds every older retired op.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + SUM_W'(acc_q[acc_p2][l]);
    rdsat_val = sat_xlen(shift_round(lane_sum, shift_p2));
  end

  // ---- Retire: accumulator update ----
  // MAC adds the sign-extended products (wrapping mod 2^AW); CLR zeroes the vector.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NB_REGS; r++)
        for (int l = 0; l < LANES; l++) acc_q[r][l] <= '0;
    end else if (update_p2) begin
      for (int r = 0; r < NB_REGS; r++) begin
        if (acc_p2 == ACC_IDX_W'(r)) begin
          for (int l = 0; l < LANES; l++) begin
            case (op_p2)
              FIR_MAC: acc_q[r][l] <= acc_q[r][l] + AW'(prod_p2[l]);
              FIR_CLR: acc_q[r][l] <= '0;
              default: ;
            endcase
          end
        end
      end
    end
  end

  // ---- Result register ----
  // Holds the response stable until the consumer takes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_o <= 1'b0;
      res_id_o    <= '0;
      res_we_o    <= 1'b0;
      res_data_o  <= '0;
    end else if (update_p2) begin
      res_valid_o <= 1'b1;
      res_id_o    <= id_p2;
      res_we_o    <= (op_p2 == FIR_RDSAT);
      res_data_o  <= (op_p2 == FIR_RDSAT) ? rdsat_val : '0;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_xifu_simd_mac.sv
// Directed scoreboard bench for fir_xifu_simd_mac (default parameters).
module tb_fir_xifu_simd_mac;
  import fir_xifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [1:0]  req_acc = 2'd0;
  logic [3:0]  req_id = 4'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [5:0]  req_shift = '0;
  logic        commit_valid = 1'b0;
  logic [3:0]  commit_id = 4'd0;
  logic        commit_kill = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [3:0]  res_id;
  logic        res_we;
  logic [31:0] res_data;

  fir_xifu_simd_mac dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_acc_i(req_acc), .req_id_i(req_id), .req_a_i(req_a), .req_b_i(req_b),
    .req_shift_i(req_shift), .commit_valid_i(commit_valid), .commit_id_i(commit_id),
    .commit_kill_i(commit_kill), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_id_o(res_id), .res_we_o(res_we), .res_data_o(res_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  id;
    logic        we;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic void push(input logic [3:0] id, input logic we, input logic [31:0] d,
                               input int c);
    sb.push_back('{id, we, d, c});
  endfunction

  function automatic logic [31:0] pk(input int l0, input int l1);
    logic [15:0] x0, x1;
    x0 = l0[15:0];
    x1 = l1[15:0];
    return {x1, x0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle commit pulse, d cycles from now; set at +2 so a pulse ending at +1 never collides.
  task automatic sched_commit(input logic [3:0] id, input logic k, input int d);
    fork
      begin
        repeat (d) @(posedge clk);
        #2;
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = k;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
      end
    join_none
  endtask

  // Present a request until accepted; t is the cycle it was accepted in.
  task automatic issue(input logic [1:0] op, input logic [1:0] acc, input logic [3:0] id,
                       input logic [31:0] a, input logic [31:0] b, input logic [5:0] sh,
                       output int t);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_acc   = acc;
    req_id    = id;
    req_a     = a;
    req_b     = b;
    req_shift = sh;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: id %0d not accepted, required ready within 40 cycles", id);
    end
    t = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Monitor: every delivered result must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got id=%0d we=%0d data=0x%0h, required none",
                 res_id, res_we, res_data);
      end else begin
        e = sb.pop_front();
        if (res_id !== e.id || res_we !== e.we || res_data !== e.data ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL result_id%0d: got id=%0d we=%0d data=0x%0h cyc=%0d, required id=%0d we=%0d data=0x%0h cyc=%0d",
                   e.id, res_id, res_we, res_data, cyc, e.id, e.we, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t0;
    logic [3:0] idv;
    logic [31:0] exp_r1, exp_r2;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_we", 64'(res_we), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    step();

    // MAC acc0 {3,-2}*{4,5} -> {12,-10}; back-to-back RDSAT -> 2
    issue(FIR_MAC, 2'd0, 4'd1, pk(3, -2), pk(4, 5), 6'd0, t);
    push(4'd1, 1'b0, 32'd0, t + 3);
    sched_commit(4'd1, 1'b0, 0);
    issue(FIR_RDSAT, 2'd0, 4'd2, '0, '0, 6'd0, t);
    push(4'd2, 1'b1, 32'd2, t + 3);
    sched_commit(4'd2, 1'b0, 0);
    repeat (4) step();

    // Commit withheld: S2 stalls, ready drops, retire the cycle after commit
    issue(FIR_MAC, 2'd1, 4'd3, pk(1, 1), pk(1, 1), 6'd0, t0);
    push(4'd3, 1'b0, 32'd0, t0 + 6);
    issue(FIR_NOP, 2'd0, 4'd4, '0, '0, 6'd0, t);
    push(4'd4, 1'b0, 32'd0, -1);
    sched_commit(4'd4, 1'b0, 0);
    sched_commit(4'd3, 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready_low", 64'(req_ready), 64'd0);
    end
    issue(FIR_RDSAT, 2'd1, 4'd5, '0, '0, 6'd0, t);
    push(4'd5, 1'b1, 32'd2, -1);
    sched_commit(4'd5, 1'b0, 0);
    repeat (5) step();

    // Killed MAC leaves acc0 untouched
    issue(FIR_MAC, 2'd0, 4'd7, pk(100, 100), pk(1, 1), 6'd0, t);
    sched_commit(4'd7, 1'b1, 0);
    issue(FIR_RDSAT, 2'd0, 4'd8, '0, '0, 6'd0, t);
    push(4'd8, 1'b1, 32'd2, -1);
    sched_commit(4'd8, 1'b0, 0);
    repeat (5) step();

    // Saturation: 512 x 2^30 wraps each acc2 lane to -2^39, then -1 more wraps to 2^39-1
    for (int i = 0; i < 512; i++) begin
      idv = i[3:0];
      issue(FIR_MAC, 2'd2, idv, pk(-32768, -32768), pk(-32768, -32768), 6'd0, t);
      push(idv, 1'b0, 32'd0, -1);
      sched_commit(idv, 1'b0, 0);
    end
    issue(FIR_RDSAT, 2'd2, 4'd0, '0, '0, 6'd0, t);
    push(4'd0, 1'b1, 32'h8000_0000, -1);
    sched_commit(4'd0, 1'b0, 0);
    issue(FIR_MAC, 2'd2, 4'd1, pk(-1, -1), pk(1, 1), 6'd0, t);
    push(4'd1, 1'b0, 32'd0, -1);
    sched_commit(4'd1, 1'b0, 0);
    issue(FIR_RDSAT, 2'd2, 4'd2, '0, '0, 6'd0, t);
    push(4'd2, 1'b1, 32'h7FFF_FFFF, -1);
    sched_commit(4'd2, 1'b0, 0);
    repeat (4) step();

    // Shift/round: acc3 = {1,2}, sum 3
`ifdef FIR_XIFU_ROUND_EN
    exp_r1 = 32'd2;
    exp_r2 = 32'd1;
`else
    exp_r1 = 32'd1;
    exp_r2 = 32'd0;
`endif
    issue(FIR_MAC, 2'd3, 4'd3, pk(1, 2), pk(1, 1), 6'd0, t);
    push(4'd3, 1'b0, 32'd0, -1);
    sched_commit(4'd3, 1'b0, 0);
    issue(FIR_RDSAT, 2'd3, 4'd4, '0, '0, 6'd1, t);
    push(4'd4, 1'b1, exp_r1, -1);
    sched_commit(4'd4, 1'b0, 0);
    issue(FIR_RDSAT, 2'd3, 4'd5, '0, '0, 6'd2, t);
    push(4'd5, 1'b1, exp_r2, -1);
    sched_commit(4'd5, 1'b0, 0);
    issue(FIR_RDSAT, 2'd0, 4'd6, '0, '0, 6'd1, t);
    push(4'd6, 1'b1, 32'd1, -1);
    sched_commit(4'd6, 1'b0, 0);
    repeat (5) step();

    // clear_i drops uncommitted ops in S1/S2; acc0 keeps its value
    issue(FIR_MAC, 2'd0, 4'd10, pk(50, 50), pk(1, 1), 6'd0, t);
    issue(FIR_MAC, 2'd0, 4'd11, pk(50, 50), pk(1, 1), 6'd0, t);
    clear = 1'b1;
    @(negedge clk);
    check("clear_ready_low", 64'(req_ready), 64'd0);
    step();
    clear = 1'b0;
    issue(FIR_RDSAT, 2'd0, 4'd12, '0, '0, 6'd0, t);
    push(4'd12, 1'b1, 32'd2, -1);
    sched_commit(4'd12, 1'b0, 0);
    repeat (5) step();

    // Result backpressure: response held stable while not taken
    res_ready = 1'b0;
    issue(FIR_NOP, 2'd0, 4'd13, '0, '0, 6'd0, t);
    push(4'd13, 1'b0, 32'd0, -1);
    sched_commit(4'd13, 1'b0, 0);
    issue(FIR_RDSAT, 2'd3, 4'd14, '0, '0, 6'd0, t);
    push(4'd14, 1'b1, 32'd3, -1);
    sched_commit(4'd14, 1'b0, 0);
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_res_valid", 64'(res_valid), 64'd1);
      check("hold_res_id", 64'(res_id), 64'd13);
    end
    step();
    res_ready = 1'b1;
    repeat (4) step();

    // Reset mid-op: op dropped, accumulators zeroed
    issue(FIR_MAC, 2'd0, 4'd15, pk(5, 5), pk(1, 1), 6'd0, t);
    sched_commit(4'd15, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_res_valid", 64'(res_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    issue(FIR_RDSAT, 2'd0, 4'd0, '0, '0, 6'd0, t);
    push(4'd0, 1'b1, 32'd0, -1);
    sched_commit(4'd0, 1'b0, 0);
    repeat (6) step();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
